// File: rtl/interrupt_interface.sv
// Machine interrupt front end: samples MSIP/MTIP/MEIP into a mip view,
// gates with mie/mstatus.MIE, arbitrates EXT>SW>TIMER, holds one trap request.
// Ports:
//   clk, rst                      clock, async active-high reset
//   all_intif_int_*_req           level interrupt sources (software/timer/external)
//   csr_intif_mie_data            mie CSR
//   csr_intif_mstatus_mie         mstatus.MIE
//   commit_intif_ack              commit took the presented trap (1-cycle pulse)
//   intif_csr_mip_data            registered mip view
//   intif_commit_has_interrupt    trap request valid
//   intif_commit_mcause_data      {1'b1, cause}, stable while request valid
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module interrupt_interface #(
  parameter int SW_CAUSE    = 3,
  parameter int TIMER_CAUSE = 7,
  parameter int EXT_CAUSE   = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       all_intif_int_software_req,
  input  logic                       all_intif_int_timer_req,
  input  logic                       all_intif_int_ext_req,
  input  logic [`REG_DATA_WIDTH-1:0] csr_intif_mie_data,
  input  logic                       csr_intif_mstatus_mie,
  input  logic                       commit_intif_ack,
  output logic [`REG_DATA_WIDTH-1:0] intif_csr_mip_data,
  output logic                       intif_commit_has_interrupt,
  output logic [`REG_DATA_WIDTH-1:0] intif_commit_mcause_data
);

  localparam int W = `REG_DATA_WIDTH;

  localparam logic [W-1:0] SRC_MASK =
    (W'(1) << SW_CAUSE) |
    (W'(1) << TIMER_CAUSE) |
    (W'(1) << EXT_CAUSE);

  localparam logic [W-2:0] SW_CODE  = (W-1)'(SW_CAUSE);
  localparam logic [W-2:0] TMR_CODE = (W-1)'(TIMER_CAUSE);
  localparam logic [W-2:0] EXT_CODE = (W-1)'(EXT_CAUSE);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    MASK
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mip_d, mip_q;
  logic [W-1:0]   cand;
  logic [W-1:0]   win_sel, sel_q;
  logic [W-2:0]   win_cause;
  logic [W-1:0]   mcause_q;
  logic           take;

  always_comb begin
    mip_d              = '0;
    mip_d[SW_CAUSE]    = all_intif_int_software_req;
    mip_d[TIMER_CAUSE] = all_intif_int_timer_req;
    mip_d[EXT_CAUSE]   = all_intif_int_ext_req;
  end

  assign cand = mip_q & csr_intif_mie_data & SRC_MASK;

  always_comb begin
    win_sel   = '0;
    win_cause = '0;
    priority case (1'b1)
      cand[EXT_CAUSE]: begin
        win_sel[EXT_CAUSE] = 1'b1;
        win_cause          = EXT_CODE;
      end
      cand[SW_CAUSE]: begin
        win_sel[SW_CAUSE] = 1'b1;
        win_cause         = SW_CODE;
      end
      cand[TIMER_CAUSE]: begin
        win_sel[TIMER_CAUSE] = 1'b1;
        win_cause            = TMR_CODE;
      end
      default: ;
    endcase
  end

  // In REQ only the latched source keeps the request alive; a newly
  // arriving higher-priority source waits for re-arbitration from IDLE.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|cand) && csr_intif_mstatus_mie) begin
          state_d = REQ;
          take    = 1'b1;
        end
      end
      REQ: begin
        if (commit_intif_ack)
          state_d = MASK;
        else if (!(|(cand & sel_q)) ||
                 !csr_intif_mstatus_mie)
          state_d = IDLE;
      end
      MASK: begin
        if (!csr_intif_mstatus_mie)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mip_q    <= '0;
      sel_q    <= '0;
      mcause_q <= '0;
    end else begin
      state_q <= state_d;
      mip_q   <= mip_d;
      if (take) begin
        sel_q    <= win_sel;
        mcause_q <= {1'b1, win_cause};
      end
    end
  end

  assign intif_csr_mip_data         = mip_q;
  assign intif_commit_has_interrupt = (state_q == REQ);
  assign intif_commit_mcause_data   = mcause_q;

endmodule
